pwm_multi_channel: RTL and testbench
====================================

// Module: pwm_multi_channel
// PURPOSE
//  Next-generation PWM generator: NUM_CH outputs share one period counter, each with its own duty.
//  Adds over the single-channel block:
//   - shadowed duty loads, applied only at period boundaries (glitch-free updates);
//   - selectable edge- or center-aligned counting;
//   - per-channel output inversion, run enable, and a period-start strobe.
//  Drives LED/backlight/audio PWM loads from the GPU control register file.
// PARAMETERS
//  BIT_WIDTH  8  width of counter, max_value and each duty word
//  NUM_CH     4  number of PWM channels
// PORTS
//  clk           in   1                   system clock, all logic on rising edge
//  rst           in   1                   synchronous, active-high reset
//  enable        in   1                   1 = counter runs; 0 = hold idle
//  max_value     in   BIT_WIDTH           top count of period (live input)
//  center_mode   in   1                   0 = edge-aligned, 1 = center-aligned; latched at boundary
//  invert        in   NUM_CH              per-channel output polarity, applied combinationally to compare
//  duty_load     in   1                   1-cycle strobe: capture duty_in into pending shadow
//  duty_in       in   NUM_CH*BIT_WIDTH    ch i at [i*BIT_WIDTH +: BIT_WIDTH]
//  pwm_out       out  NUM_CH              registered PWM outputs
//  period_start  out  1                   registered 1-cycle pulse, first cycle of each period
// BEHAVIOUR
//  Reset:
//   - cnt=0, dir=up, mode_act=edge, duty_act=0, duty_pend=0, pend_flag=0;
//   - pwm_out=0, period_start=0.
//  Edge mode counter:
//   - cnt 0,1..max_value, then 0; period = max_value+1 cycles.
//  Center mode counter:
//   - cnt 0 up to max_value, then down max_value-1..1, then 0; period = 2*max_value cycles.
//  Wrap edge:
//   - the clock edge that loads cnt with 0 while enable=1;
//   - also taken immediately if cnt >= max_value after max_value is lowered
//     (edge mode, or center mode on the up-count).
//   - max_value=0: cnt stays 0 and every cycle is a wrap.
//  At each wrap edge:
//   - mode_act <= center_mode;
//   - if pend_flag: duty_act <= duty_pend, pend_flag <= 0.
//  Shadow load:
//   - duty_load=1 -> duty_pend <= duty_in, pend_flag <= 1.
//   - duty_load coinciding with a wrap edge: duty_in goes directly to duty_act; pend_flag ends 0.
//   - Two loads within one period: the last one wins.
//  Compare:
//   - raw[i] = (cnt < duty_act[i]);
//   - pwm_out[i] <= raw[i] ^ invert[i], registered, 1 cycle after the cnt value it reflects.
//   - Edge mode: duty 0 -> always inactive; duty > max_value -> always active.
//   - Center mode: the active window is symmetric about cnt=0.
//  period_start <= 1 for the cycle after a wrap edge (aligned with pwm_out for cnt=0).
//  enable=0:
//   - cnt held at 0, dir=up, period_start=0, pwm_out[i] <= invert[i];
//   - pending duty and mode are transferred every cycle (no period in progress).
//   - On enable rising: counting starts at cnt=0; the first period_start follows 1 cycle later.
//  rst mid-period dominates everything: all state returns to reset values on that edge.
//  All comparisons and counting are unsigned, BIT_WIDTH bits; the counter never overflows
//  because wrap occurs at max_value.
// STRUCTURE
//  Package pwm_pkg:
//   - typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t;
//   - shared by future PWM blocks.
//  Sub-module pwm_period_counter:
//   - owns cnt, dir, mode_act and the wrap detection;
//   - outputs cnt and a wrap pulse.
//  Top level owns duty_pend/duty_act/pend_flag and a generate loop of NUM_CH compare+register slices.
// TESTING (BIT_WIDTH=8, NUM_CH=4 unless stated)
//  1 Reset: rst high 3 cycles mid-run -> pwm_out=0, period_start=0.
//    Then duty all 0, invert=0 -> pwm_out 0 for 512 cycles.
//  2 Edge, max=255, load duties {0,64,128,255}
//    -> high counts per 256-cycle period {0,64,128,255}.
//    max=99, duty 100 -> 100/100 high.
//  3 Shadow: ch0 duty 200 running, load 10 at cnt=50
//    -> rest of current period unchanged (200 highs total); next period 10 highs.
//    Load on the wrap cycle -> applied immediately.
//  4 Center, max=10, duty 4 -> period_start every 20 cycles, 7 high cycles per period,
//    contiguous across the boundary.
//  5 Lower max_value 255->20 while cnt=100 -> wrap on the next edge, period_start pulse,
//    then 21-cycle periods.
//  6 invert=4'b0001, duty 0 -> ch0 constant 1.
//    enable=0 -> pwm_out==invert, no period_start; re-enable -> period_start after 1 cycle.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions used by the multi-channel generator and future PWM blocks.
//   pwm_mode_t : counting style of the period counter (edge- or center-aligned)
//   pwm_dir_t  : count direction, only meaningful in center-aligned mode
package pwm_pkg;

  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t;

  typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_t;

endpackage

// File: rtl/pwm_period_counter.sv
// Shared period counter for the PWM channels.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable        : 1 = count, 0 = hold at zero (mode follows center_mode every cycle)
//   max_value     : top count of the period, sampled live
//   center_mode   : requested counting style, takes effect at the next wrap
//   cnt           : current count value
//   wrap          : high in the cycle whose rising edge reloads cnt with 0 while enabled
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [BIT_WIDTH-1:0] max_value,
  input  logic                 center_mode,
  output logic [BIT_WIDTH-1:0] cnt,
  output logic                 wrap
);

  logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
  pwm_dir_t             dir_q, dir_d;
  pwm_mode_t            mode_q, mode_d;
  logic                 wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    if (!enable) begin
      cnt_d  = '0;
      dir_d  = DIR_UP;
      mode_d = pwm_mode_t'(center_mode);
    end else begin
      if (mode_q == PWM_EDGE) begin
        // >= also catches a count left above a freshly lowered max_value
        if (cnt_q >= max_value) wrap_d = 1'b1;
        else                    cnt_d  = cnt_q + BIT_WIDTH'(1);
      end else if (dir_q == DIR_UP) begin
        if (cnt_q < max_value) begin
          cnt_d = cnt_q + BIT_WIDTH'(1);
        end else if ((cnt_q == max_value) && (max_value > BIT_WIDTH'(1))) begin
          cnt_d = max_value - BIT_WIDTH'(1);
          dir_d = DIR_DOWN;
        end else begin
          // max_value of 0 or 1 has no down-count; above max_value means it was lowered
          wrap_d = 1'b1;
        end
      end else begin
        if (cnt_q <= BIT_WIDTH'(1)) wrap_d = 1'b1;
        else                        cnt_d  = cnt_q - BIT_WIDTH'(1);
      end

      if (wrap_d) begin
        cnt_d  = '0;
        dir_d  = DIR_UP;
        mode_d = pwm_mode_t'(center_mode);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      mode_q <= PWM_EDGE;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_d;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: NUM_CH outputs share one period counter, each with its
// own shadowed duty word that is applied only at period boundaries.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable        : 1 = run, 0 = idle (outputs equal invert, no period_start)
//   max_value     : top count of the period (live)
//   center_mode   : 0 = edge-aligned, 1 = center-aligned, latched at period boundary
//   invert        : per-channel output polarity
//   duty_load     : one-cycle strobe capturing duty_in into the pending shadow
//   duty_in       : packed duty words, channel i at [i*BIT_WIDTH +: BIT_WIDTH]
//   pwm_out       : registered PWM outputs
//   period_start  : registered pulse aligned with the output for cnt = 0
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned NUM_CH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [BIT_WIDTH-1:0]          max_value,
  input  logic                          center_mode,
  input  logic [NUM_CH-1:0]             invert,
  input  logic                          duty_load,
  input  logic [NUM_CH*BIT_WIDTH-1:0]   duty_in,
  output logic [NUM_CH-1:0]             pwm_out,
  output logic                          period_start
);

  logic [BIT_WIDTH-1:0] cnt;
  logic                 wrap;
  logic                 xfer;

  logic [NUM_CH-1:0][BIT_WIDTH-1:0] duty_pend_q, duty_pend_d;
  logic [NUM_CH-1:0][BIT_WIDTH-1:0] duty_act_q, duty_act_d;
  logic                             pend_flag_q, pend_flag_d;
  logic                             period_start_q, period_start_d;

  pwm_period_counter #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .max_value   (max_value),
    .center_mode (center_mode),
    .cnt         (cnt),
    .wrap        (wrap)
  );

  // While idle there is no period in progress, so shadow contents move through at once.
  assign xfer = wrap | ~enable;

  always_comb begin
    duty_pend_d = duty_pend_q;
    duty_act_d  = duty_act_q;
    pend_flag_d = pend_flag_q;
    if (duty_load) begin
      duty_pend_d = duty_in;
      if (xfer) begin
        duty_act_d  = duty_in;
        pend_flag_d = 1'b0;
      end else begin
        pend_flag_d = 1'b1;
      end
    end else if (xfer && pend_flag_q) begin
      duty_act_d  = duty_pend_q;
      pend_flag_d = 1'b0;
    end
  end

  // Registered alongside pwm_out, so it lines up with the output for cnt = 0.
  always_comb begin
    period_start_d = enable & (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_pend_q    <= '0;
      duty_act_q     <= '0;
      pend_flag_q    <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      duty_pend_q    <= duty_pend_d;
      duty_act_q     <= duty_act_d;
      pend_flag_q    <= pend_flag_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic pwm_q, pwm_d;

    always_comb begin
      pwm_d = invert[g];
      if (enable) pwm_d = (cnt < duty_act_q[g]) ^ invert[g];
    end

    always_ff @(posedge clk) begin
      if (rst) pwm_q <= 1'b0;
      else     pwm_q <= pwm_d;
    end

    assign pwm_out[g] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
module tb_pwm_multi_channel;

  localparam int unsigned BW  = 8;
  localparam int unsigned NCH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [BW-1:0]     max_value;
  logic              center_mode;
  logic [NCH-1:0]    invert;
  logic              duty_load;
  logic [NCH*BW-1:0] duty_in;
  logic [NCH-1:0]    pwm_out;
  logic              period_start;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  int          hi[NCH];
  int          ps_cnt;
  int          first_ps;
  logic [63:0] ch0_vec;

  always #5 clk = ~clk;

  pwm_multi_channel #(
    .BIT_WIDTH (BW),
    .NUM_CH    (NCH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .max_value    (max_value),
    .center_mode  (center_mode),
    .invert       (invert),
    .duty_load    (duty_load),
    .duty_in      (duty_in),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input int obs);
    int exp;
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_hi(input string tag, input int e0, input int e1, input int e2, input int e3);
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2); exp_q.push_back(e3);
    check({tag, "_ch0"}, hi[0]);
    check({tag, "_ch1"}, hi[1]);
    check({tag, "_ch2"}, hi[2]);
    check({tag, "_ch3"}, hi[3]);
  endtask

  task automatic load_duty(input logic [BW-1:0] d0, input logic [BW-1:0] d1,
                           input logic [BW-1:0] d2, input logic [BW-1:0] d3);
    duty_in   = {d3, d2, d1, d0};
    duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
  endtask

  // Waits for the next period_start sample; leaves the bench on that sample.
  task automatic wait_ps(input string tag, input int budget);
    int found;
    found = 0;
    exp_q.push_back(1);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (period_start === 1'b1) begin
        found = 1;
        break;
      end
    end
    check(tag, found);
  endtask

  // Accumulates n samples starting with the current one; optionally strobes a ch0
  // duty load right after sample load_idx.
  task automatic measure(input int n, input int load_idx, input logic [BW-1:0] load_val);
    for (int c = 0; c < NCH; c++) hi[c] = 0;
    ps_cnt   = 0;
    first_ps = 0;
    ch0_vec  = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      if (i == load_idx + 1) duty_load = 1'b0;
      for (int c = 0; c < NCH; c++) hi[c] += int'(pwm_out[c]);
      ps_cnt += int'(period_start);
      if (i == 0) first_ps = int'(period_start);
      if (i < 64) ch0_vec[i] = pwm_out[0];
      if (i == load_idx) begin
        duty_in   = {{(NCH-1)*BW{1'b0}}, load_val};
        duty_load = 1'b1;
      end
    end
    duty_load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    enable      = 1'b1;
    max_value   = 8'd255;
    center_mode = 1'b0;
    invert      = '0;
    duty_load   = 1'b0;
    duty_in     = '0;
    repeat (3) tick();
    exp_q.push_back(0); check("reset_pwm", int'(pwm_out));
    exp_q.push_back(0); check("reset_ps", int'(period_start));
    rst = 1'b0;

    // Running state, then a mid-period reset
    load_duty(8'd50, 8'd60, 8'd70, 8'd80);
    wait_ps("pre_rst_ps", 600);
    measure(256, -1, '0);
    expect_hi("pre_rst", 50, 60, 70, 80);
    repeat (30) tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_q.push_back(0);
      check("mid_rst_out", int'({period_start, pwm_out}));
    end
    rst = 1'b0;
    tick();
    measure(512, -1, '0);
    expect_hi("post_rst", 0, 0, 0, 0);
    exp_q.push_back(2); check("post_rst_ps_cnt", ps_cnt);
    exp_q.push_back(1); check("post_rst_first_ps", first_ps);

    // Edge mode duty sweep
    load_duty(8'd0, 8'd64, 8'd128, 8'd255);
    wait_ps("edge_ps", 600);
    measure(256, -1, '0);
    expect_hi("edge255", 0, 64, 128, 255);
    exp_q.push_back(1); check("edge255_ps_cnt", ps_cnt);

    max_value = 8'd99;
    load_duty(8'd100, 8'd99, 8'd0, 8'd50);
    wait_ps("edge99_ps", 400);
    measure(100, -1, '0);
    expect_hi("edge99", 100, 99, 0, 50);
    exp_q.push_back(1); check("edge99_ps_cnt", ps_cnt);

    // Shadowed loads
    max_value = 8'd255;
    load_duty(8'd200, 8'd0, 8'd0, 8'd0);
    wait_ps("shadow_ps", 600);
    measure(256, 50, 8'd10);
    exp_q.push_back(200); check("shadow_cur", hi[0]);
    tick();
    measure(256, 254, 8'd30);
    exp_q.push_back(10); check("shadow_next", hi[0]);
    exp_q.push_back(1);  check("shadow_next_ps", first_ps);
    tick();
    measure(256, -1, '0);
    exp_q.push_back(30); check("wrap_load_direct", hi[0]);
    exp_q.push_back(1);  check("wrap_load_ps", first_ps);

    // Center-aligned mode
    center_mode = 1'b1;
    max_value   = 8'd10;
    load_duty(8'd4, 8'd0, 8'd11, 8'd10);
    wait_ps("center_ps", 600);
    measure(20, -1, '0);
    expect_hi("center", 7, 0, 20, 19);
    exp_q.push_back(1); check("center_ps_cnt", ps_cnt);
    exp_q.push_back(int'(20'hE000F)); check("center_shape", int'(ch0_vec[19:0]));
    tick();
    measure(20, -1, '0);
    exp_q.push_back(1); check("center_period_first", first_ps);
    exp_q.push_back(1); check("center_period_cnt", ps_cnt);

    // Lowering max_value while the count is above it
    center_mode = 1'b0;
    max_value   = 8'd255;
    load_duty(8'd5, 8'd25, 8'd0, 8'd21);
    wait_ps("lower_ps", 1200);
    repeat (99) tick();
    max_value = 8'd20;
    tick();
    exp_q.push_back(0); check("lower_wrap_edge", int'(period_start));
    tick();
    exp_q.push_back(1); check("lower_ps_pulse", int'(period_start));
    measure(21, -1, '0);
    expect_hi("lower", 5, 21, 0, 21);
    exp_q.push_back(1); check("lower_ps_cnt", ps_cnt);
    tick();
    measure(21, -1, '0);
    exp_q.push_back(1); check("p21_first", first_ps);
    exp_q.push_back(1); check("p21_cnt", ps_cnt);

    // Inversion, idle and re-enable
    invert = 4'b0001;
    load_duty(8'd0, 8'd0, 8'd0, 8'd0);
    wait_ps("inv_ps", 100);
    measure(21, -1, '0);
    expect_hi("inv", 21, 0, 0, 0);
    enable = 1'b0;
    invert = 4'b1010;
    tick();
    measure(10, -1, '0);
    expect_hi("idle", 0, 10, 0, 10);
    exp_q.push_back(0); check("idle_ps_cnt", ps_cnt);
    load_duty(8'd3, 8'd0, 8'd0, 8'd0);
    invert = 4'b0000;
    enable = 1'b1;
    tick();
    exp_q.push_back(1); check("reenable_ps", int'(period_start));
    measure(21, -1, '0);
    exp_q.push_back(3); check("reenable_duty", hi[0]);
    exp_q.push_back(1); check("reenable_ps_cnt", ps_cnt);

    // max_value = 0: every cycle is a wrap
    max_value = 8'd0;
    tick();
    tick();
    measure(8, -1, '0);
    exp_q.push_back(8); check("max0_ps_cnt", ps_cnt);
    exp_q.push_back(8); check("max0_ch0", hi[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
